// File: rtl/majority_voter.sv
// Registered bitwise 2-of-3 (TMR) majority voter with sticky per-copy fault flags.
// Optional saturating disagreement counter enabled by `define MAJORITY_VOTER_ERR_CNT_EN.
module majority_voter #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic             clr_faults,
   output logic [WIDTH-1:0] f,
   output logic             out_valid,
   output logic             disagree,
   output logic             fault_a,
   output logic             fault_b,
   output logic             fault_c
`ifdef MAJORITY_VOTER_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   // Reject out-of-range configurations at elaboration.
   if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1 || CNT_W > 32) begin : g_param_check
      $error("majority_voter: WIDTH must be 1..64 and CNT_W 1..32");
   end

   logic [WIDTH-1:0] vote_c;
   logic             mismatch_c;
   logic             lose_a_c;
   logic             lose_b_c;
   logic             lose_c_c;

   // Per-lane vote plus loser detection; loser terms are gated so idle X inputs never leak.
   always_comb begin
      vote_c     = (a & b) | (a & c) | (b & c);
      mismatch_c = |((a ^ b) | (a ^ c));
      lose_a_c   = in_valid & (|(a ^ vote_c));
      lose_b_c   = in_valid & (|(b ^ vote_c));
      lose_c_c   = in_valid & (|(c ^ vote_c));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f         <= '0;
         out_valid <= 1'b0;
         disagree  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            f        <= vote_c;
            disagree <= mismatch_c;
         end
      end
   end

   // Sticky flags: a new loss event in the same cycle overrides a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_a <= 1'b0;
         fault_b <= 1'b0;
         fault_c <= 1'b0;
      end else begin
         fault_a <= (fault_a & ~clr_faults) | lose_a_c;
         fault_b <= (fault_b & ~clr_faults) | lose_b_c;
         fault_c <= (fault_c & ~clr_faults) | lose_c_c;
      end
   end

`ifdef MAJORITY_VOTER_ERR_CNT_EN
   // Saturating count of voted words that showed any disagreement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (in_valid && mismatch_c && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_majority_voter.sv
// Self-checking bench for majority_voter: WIDTH=1 and WIDTH=8 instances, directed tables,
// multi-cycle corner sequences, and randomized traffic against a lane-counting reference model.
module tb_majority_voter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // WIDTH=1 instance
   logic v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, clr1 = 1'b0;
   logic f1, ov1, dis1, fa1, fb1, fc1;
   // WIDTH=8 instance, narrow counter to reach saturation
   logic       v8 = 1'b0, clr8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, c8 = '0;
   logic [7:0] f8;
   logic       ov8, dis8, fa8, fb8, fc8;
`ifdef MAJORITY_VOTER_ERR_CNT_EN
   logic [15:0] cnt1;
   logic [1:0]  cnt8;
`endif

   majority_voter #(.WIDTH(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1), .clr_faults(clr1),
      .f(f1), .out_valid(ov1), .disagree(dis1), .fault_a(fa1), .fault_b(fb1), .fault_c(fc1)
`ifdef MAJORITY_VOTER_ERR_CNT_EN
      , .err_cnt(cnt1)
`endif
   );

   majority_voter #(.WIDTH(8), .CNT_W(2)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8), .clr_faults(clr8),
      .f(f8), .out_valid(ov8), .disagree(dis8), .fault_a(fa8), .fault_b(fb8), .fault_c(fc8)
`ifdef MAJORITY_VOTER_ERR_CNT_EN
      , .err_cnt(cnt8)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: count ones per lane; majority is count>=2, disagreement is count 1 or 2.
   function automatic void ref_vote(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                    output logic [7:0] m, output logic dis,
                                    output logic ea, output logic eb, output logic ec);
      m = '0; dis = 1'b0; ea = 1'b0; eb = 1'b0; ec = 1'b0;
      for (int i = 0; i < 8; i++) begin
         int n;
         n = int'(a[i]) + int'(b[i]) + int'(c[i]);
         m[i] = (n >= 2);
         if (n == 1 || n == 2) dis = 1'b1;
         if (a[i] != m[i]) ea = 1'b1;
         if (b[i] != m[i]) eb = 1'b1;
         if (c[i] != m[i]) ec = 1'b1;
      end
   endfunction

   typedef struct {
      logic v, a, b, c, clr;
      logic f, ov, dis, fa, fb, fc;
   } vec1_t;

   vec1_t tbl [9];

   // Model state for the random phase
   logic [7:0] mf;
   logic       mov, mdis, mfa, mfb, mfc;
   int         mcnt;

   initial begin
      //           v  a  b  c  clr  f ov dis fa fb fc
      tbl[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
      tbl[1] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0};
      tbl[2] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1,1'b1};
      tbl[3] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b1};
      tbl[4] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0};
      tbl[5] = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
      tbl[6] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1,1'b0};
      tbl[7] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
      tbl[8] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};

      // Reset and idle: out_valid stays low
      tick(); tick();
      #2 rst = 1'b0;
      tick();
      check("idle_ov1", 64'(ov1), 64'd0);
      check("idle_ov8", 64'(ov8), 64'd0);
      check("idle_fa1", 64'(fa1), 64'd0);

      // WIDTH=1 table
      for (int i = 0; i < 9; i++) begin
         v1 = tbl[i].v; a1 = tbl[i].a; b1 = tbl[i].b; c1 = tbl[i].c; clr1 = tbl[i].clr;
         tick();
         check($sformatf("t%0d_f", i),   64'(f1),   64'(tbl[i].f));
         check($sformatf("t%0d_ov", i),  64'(ov1),  64'(tbl[i].ov));
         check($sformatf("t%0d_dis", i), 64'(dis1), 64'(tbl[i].dis));
         check($sformatf("t%0d_fa", i),  64'(fa1),  64'(tbl[i].fa));
         check($sformatf("t%0d_fb", i),  64'(fb1),  64'(tbl[i].fb));
         check($sformatf("t%0d_fc", i),  64'(fc1),  64'(tbl[i].fc));
      end
      v1 = 1'b0; clr1 = 1'b0;

      // WIDTH=8: different copies lose in different lanes
      v8 = 1'b1; a8 = 8'hF0; b8 = 8'hFF; c8 = 8'h0F;
      tick();
      check("w8_f", 64'(f8), 64'hFF);
      check("w8_ov", 64'(ov8), 64'd1);
      check("w8_dis", 64'(dis8), 64'd1);
      check("w8_fa", 64'(fa8), 64'd1);
      check("w8_fb", 64'(fb8), 64'd0);
      check("w8_fc", 64'(fc8), 64'd1);

      // Idle cycles with random inputs: nothing changes except out_valid
      v8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
         tick();
         check("hold_f", 64'(f8), 64'hFF);
         check("hold_dis", 64'(dis8), 64'd1);
         check("hold_ov", 64'(ov8), 64'd0);
         check("hold_flags", 64'({fa8, fb8, fc8}), 64'b101);
      end

      // Asynchronous reset mid-cycle, no clock edge
      #2 rst = 1'b1;
      #1;
      check("arst_f8", 64'(f8), 64'd0);
      check("arst_dis8", 64'(dis8), 64'd0);
      check("arst_flags8", 64'({fa8, fb8, fc8}), 64'd0);
      check("arst_f1", 64'(f1), 64'd0);
      check("arst_ov1", 64'(ov1), 64'd0);
`ifdef MAJORITY_VOTER_ERR_CNT_EN
      check("arst_cnt1", 64'(cnt1), 64'd0);
`endif
      tick();
      #2 rst = 1'b0;
      tick();

`ifdef MAJORITY_VOTER_ERR_CNT_EN
      // Saturating counter, CNT_W=2
      v8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a8 = 8'h01; b8 = 8'h00; c8 = 8'h00;
         tick();
         check($sformatf("cnt_%0d", i), 64'(cnt8), 64'((i < 3) ? i + 1 : 3));
      end
      v8 = 1'b0; clr8 = 1'b1;
      tick();
      check("cnt_clr", 64'(cnt8), 64'd3);
      check("cnt_clr_fa", 64'(fa8), 64'd0);
      clr8 = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("cnt_rst", 64'(cnt8), 64'd0);
      tick();
      #2 rst = 1'b0;
      tick();
`endif

      // Random traffic against the reference model (state is zero after reset)
      mf = '0; mov = 1'b0; mdis = 1'b0; mfa = 1'b0; mfb = 1'b0; mfc = 1'b0; mcnt = 0;
      for (int k = 0; k < 400; k++) begin
         logic [7:0] m;
         logic       d, ea, eb, ec;
         v8   = ($urandom_range(3) != 0);
         clr8 = ($urandom_range(9) == 0);
         a8   = 8'($urandom);
         b8   = ($urandom_range(1) != 0) ? a8 : 8'($urandom);
         c8   = ($urandom_range(1) != 0) ? a8 ^ (8'd1 << $urandom_range(7)) : 8'($urandom);
         if ($urandom_range(3) == 0) b8 = 8'($urandom);
         ref_vote(a8, b8, c8, m, d, ea, eb, ec);
         mov = v8;
         if (v8) begin
            mf = m; mdis = d;
            if (d && mcnt < 3) mcnt++;
         end
         mfa = (mfa && !clr8) || (v8 && ea);
         mfb = (mfb && !clr8) || (v8 && eb);
         mfc = (mfc && !clr8) || (v8 && ec);
         tick();
         check("rnd_f", 64'(f8), 64'(mf));
         check("rnd_ov", 64'(ov8), 64'(mov));
         check("rnd_dis", 64'(dis8), 64'(mdis));
         check("rnd_flags", 64'({fa8, fb8, fc8}), 64'({mfa, mfb, mfc}));
`ifdef MAJORITY_VOTER_ERR_CNT_EN
         check("rnd_cnt", 64'(cnt8), 64'(mcnt));
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/majority_voter.md
Name: majority_voter

Overview:
- Registered bitwise 2-of-3 majority voter (triple-modular-redundancy voter) with per-input fault detection.
- Sits after three redundant copies of a datapath. It delivers the voted word one cycle later, flags any disagreement between the copies, and records which copy was outvoted.
- Fully synchronous to one clock, with an asynchronous reset.

Parameters:
- WIDTH, 1, bit width of each voted word (lanes voted independently); legal range 1..64.
- CNT_W, 16, width of the saturating disagreement counter; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  a/b/c carry a word to vote this cycle.
- a  input  WIDTH  redundant copy A.
- b  input  WIDTH  redundant copy B.
- c  input  WIDTH  redundant copy C.
- clr_faults  input  1  synchronous clear of the sticky fault flags.
- f  output  WIDTH  registered voted word.
- out_valid  output  1  f updated on the previous edge.
- disagree  output  1  registered; the last voted word had at least one lane where a, b and c were not all equal.
- fault_a  output  1  sticky; A was outvoted in some lane since the last clear.
- fault_b  output  1  sticky; B was outvoted in some lane since the last clear.
- fault_c  output  1  sticky; C was outvoted in some lane since the last clear.
- err_cnt  output  CNT_W  (present only with the optional feature) saturating count of voted words with disagree.

Behaviour:
- Reset: while rst=1, all outputs are 0 immediately (asynchronous), independent of clk. This covers f, out_valid, disagree, fault_a/b/c and err_cnt. On rst deassertion, normal operation resumes at the next clk edge.
- Vote function, per bit i: m[i] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]). The function is combinational internally.
- Latency 1: at a clk edge with in_valid=1:
  - f <= m
  - out_valid <= 1
  - disagree <= OR over lanes of NOT(a[i]==b[i]==c[i])
- At a clk edge with in_valid=0: f and disagree hold their values; out_valid <= 0.
- There is no backpressure; a new word may be voted on every cycle.
- Fault detection, at a clk edge with in_valid=1:
  - fault_a sets if (a XOR m) != 0.
  - fault_b and fault_c set likewise from b and c.
  - In a multi-bit word, different inputs may lose in different lanes; every such flag sets in the same cycle.
  - Flags are sticky; they clear only on rst, or when clr_faults=1 at a clk edge.
- Simultaneous clr_faults=1 and a new fault event in the same cycle: the flag ends at 1 (set wins). Flags with no new event clear.
- clr_faults has no effect on f, out_valid, disagree or err_cnt.
- Inputs with in_valid=0 are ignored entirely; they may be X.
- For WIDTH=1, disagree=1 implies exactly one fault flag event in that cycle.

Optional Feature:
- Macro MAJORITY_VOTER_ERR_CNT_EN.
- Defined:
  - Port err_cnt exists.
  - At each clk edge with in_valid=1 and a disagreement in the current inputs, err_cnt increments by 1.
  - err_cnt saturates at 2^CNT_W-1 and holds there.
  - err_cnt is cleared only by rst; clr_faults does not affect it.
- Undefined: err_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, WIDTH=1: assert rst mid-cycle with no clk edge -> all outputs 0 immediately. Release rst, in_valid=0 -> out_valid stays 0.
- WIDTH=1 votes, in_valid=1, one per cycle:
  - a,b,c=0,0,0 -> f=0, disagree=0.
  - a,b,c=1,0,1 -> f=1, disagree=1, fault_b=1.
  - a,b,c=0,0,1 -> f=0, disagree=1, fault_c=1, fault_b still 1.
  - Each result appears one edge later with out_valid=1.
- WIDTH=8, one word: a=0xF0, b=0xFF, c=0x0F -> f=0xFF, disagree=1, fault_a=1, fault_c=1, fault_b=0.
- Flag clear:
  - Set fault_a; clr_faults=1 alone -> fault_a=0 next edge.
  - clr_faults=1 together with a new A fault -> fault_a remains 1.
- in_valid=0 for 3 cycles with random a/b/c -> f and disagree hold, out_valid=0, no flag change.
- With MAJORITY_VOTER_ERR_CNT_EN, CNT_W=2: 5 consecutive disagreeing votes -> err_cnt sequence 1,2,3,3,3. clr_faults leaves err_cnt unchanged; rst -> err_cnt=0.
